regfile_cc_sb: RTL and testbench
================================

# regfile_cc_sb

Parametrised general-purpose register file with condition codes and a per-register busy scoreboard. It is the next-generation datapath register file behind the SR1/SR2 operand muxes, with data width and register count set by parameters. It adds synchronous reset, NZP condition-code generation on load, optional write-to-read bypass, and reservation tracking so that multi-cycle loads can stall dependent reads.

## Interface
- DATA_W, default 16: register and BUS width.
- NREGS, default 8: number of registers; power of two, at least 2. AW = clog2(NREGS).
- BYPASS, default 1: 1 means same-cycle write data is forwarded to the read ports; 0 means no forwarding.

Ports:
- i_Clk  in  1  clock; all state updates on the rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- BUS  in  DATA_W  write data.
- DR  in  AW  destination register index.
- LD_REG  in  1  write BUS into register DR.
- LD_CC  in  1  update NZP from BUS.
- RESV  in  1  reserve register RESV_DR, marking it busy.
- RESV_DR  in  AW  index of the register to reserve.
- SR1_SEL, SR2_SEL  in  AW  read indices.
- SR1_OUT, SR2_OUT  out  DATA_W  read data, combinational.
- SR1_BUSY, SR2_BUSY  out  1  the selected register is busy.
- STALL  out  1  SR1_BUSY OR SR2_BUSY.
- NZP  out  3  condition codes, with N as bit 2.
- RESV_ERR  out  1  registered; pulses for one cycle when a reservation is rejected.

## Operation
- Reset, sampled on the rising edge with i_Rst=1:
  - all registers become 0;
  - all busy bits become 0;
  - NZP becomes 3'b010;
  - RESV_ERR becomes 0.
  - i_Rst overrides every other input in that cycle.
- Write: when LD_REG=1, reg[DR] <= BUS and busy[DR] <= 0.
- Condition codes: when LD_CC=1, NZP is set from BUS, independent of LD_REG:
  - 3'b100 if BUS[DATA_W-1]=1;
  - 3'b010 if BUS is zero;
  - 3'b001 otherwise.
- Reserve: when RESV=1 and busy[RESV_DR]=0, busy[RESV_DR] <= 1.
  - If busy[RESV_DR] is already 1, the request is ignored and RESV_ERR=1 on the next cycle.
- Simultaneous write and reserve:
  - Same index: the reserve wins, so the busy bit ends at 1 and there is no error. The write still updates the register value.
  - Different indices: both take effect.
  - Reserve of a busy register that is being written in the same cycle: allowed, the busy bit stays 1, no error.
- Read:
  - SRx_OUT = reg[SRx_SEL].
  - When BYPASS=1, LD_REG=1 and DR==SRx_SEL, SRx_OUT = BUS.
- Busy report:
  - SRx_BUSY = busy[SRx_SEL].
  - When BYPASS=1, SRx_BUSY is forced to 0 if the same cycle has LD_REG=1 with DR==SRx_SEL and no reserve of that index.
  - When BYPASS=0, SRx_BUSY reflects stored state only.
- Both read ports may select the same register; each port behaves independently.

## Timing
- Write latency: 1 cycle, visible on the read ports the cycle after LD_REG (or the same cycle through bypass).
- NZP: updated on the edge where LD_CC=1; visible the next cycle.
- Busy bits: set or cleared on the edge; SRx_BUSY and STALL are combinational from the stored bits plus the bypass term.
- RESV_ERR: high for exactly one cycle after each rejected request; it is not sticky.
- Reset is held for one edge minimum; after reset, all outputs are valid in the same cycle.
- Out-of-range indices are impossible because every index is exactly AW bits.

## Structure
- A shared package holds:
  - the NZP encodings CC_N=3'b100, CC_Z=3'b010, CC_P=3'b001;
  - the reset NZP value;
  - a function that computes NZP from a DATA_W-wide word.
- One sub-module, regfile_read_port, instantiated twice. It takes the storage array, busy vector, SEL and the write/reserve signals, and produces OUT and BUSY including the bypass logic.
- Storage, busy vector, NZP and RESV_ERR live in the top module.

## Test plan
- Reset, then read all registers:
  - expected: all 0, NZP=3'b010, STALL=0.
- LD_REG with DR=3, BUS=16'h8001, LD_CC=1, then read SR1_SEL=3 on the next cycle:
  - expected: SR1_OUT=16'h8001, NZP=3'b100.
  - Then LD_CC with BUS=0 gives NZP=3'b010; LD_CC with BUS=16'h0005 gives NZP=3'b001.
- BYPASS=1: in one cycle LD_REG with DR=5, BUS=16'h1234, SR2_SEL=5:
  - expected: SR2_OUT=16'h1234 in that cycle.
  - With BYPASS=0, the same stimulus gives the old value.
- RESV with RESV_DR=2, then SR1_SEL=2:
  - expected: SR1_BUSY=1 and STALL=1.
  - LD_REG to DR=2 with BYPASS=1 gives STALL=0 in the write cycle; BUSY stays 0 afterwards.
- RESV on register 2 twice in consecutive cycles:
  - expected: RESV_ERR=1 for one cycle after the second request.
  - Same-cycle RESV plus LD_REG on register 2 leaves busy=1 with no error.
- Parameter sweep DATA_W=32, NREGS=16: write and read back r15 = 32'hFFFF_FFFF.
  - expected: NZP=3'b100.
  - Asserting i_Rst mid-reservation clears all busy bits and registers.

Source files
------------

// File: rtl/regfile_cc_sb_pkg.sv
// Shared definitions for the register file: condition-code encodings and NZP helper.
package regfile_cc_sb_pkg;

    localparam logic [2:0] CC_N    = 3'b100;
    localparam logic [2:0] CC_Z    = 3'b010;
    localparam logic [2:0] CC_P    = 3'b001;
    localparam logic [2:0] NZP_RST = CC_Z;

    // Widest data word the NZP helper accepts; callers zero-extend narrower words.
    localparam int MAX_DATA_W = 64;

    // NZP for a word of 'width' significant bits held in the low end of 'word'.
    function automatic logic [2:0] nzp_of(input logic [MAX_DATA_W-1:0] word,
                                          input int unsigned          width);
        logic [2:0] cc;
        if (word[width-1])
            cc = CC_N;
        else if (word == '0)
            cc = CC_Z;
        else
            cc = CC_P;
        return cc;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: selects a register and its busy bit, with optional same-cycle write forwarding.
module regfile_read_port
    import regfile_cc_sb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic [NREGS-1:0][DATA_W-1:0] regs,
    input  logic [NREGS-1:0]             busy,
    input  logic [AW-1:0]                sel,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [AW-1:0]                wr_idx,
    input  logic                         wr_en,
    input  logic [AW-1:0]                resv_idx,
    input  logic                         resv_en,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_busy
);

    logic wr_hit;
    logic resv_hit;

    assign wr_hit   = (BYPASS != 0) && wr_en && (wr_idx == sel);
    assign resv_hit = resv_en && (resv_idx == sel);

    // A write landing on the selected register forwards its data and, unless the
    // same register is being re-reserved, releases the stall early.
    always_comb begin
        rd_data = regs[sel];
        rd_busy = busy[sel];
        if (wr_hit) begin
            rd_data = wr_data;
            if (!resv_hit)
                rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_cc_sb.sv
// Register file with NZP condition codes and a per-register busy scoreboard.
module regfile_cc_sb
    import regfile_cc_sb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [DATA_W-1:0] BUS,
    input  logic [AW-1:0]     DR,
    input  logic              LD_REG,
    input  logic              LD_CC,
    input  logic              RESV,
    input  logic [AW-1:0]     RESV_DR,
    input  logic [AW-1:0]     SR1_SEL,
    input  logic [AW-1:0]     SR2_SEL,
    output logic [DATA_W-1:0] SR1_OUT,
    output logic [DATA_W-1:0] SR2_OUT,
    output logic              SR1_BUSY,
    output logic              SR2_BUSY,
    output logic              STALL,
    output logic [2:0]        NZP,
    output logic              RESV_ERR
);

    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic [NREGS-1:0]             busy;
    logic [NREGS-1:0]             busy_nxt;
    logic [2:0]                   nzp_q;
    logic                         resv_err_q;
    logic                         wr_same;
    logic                         resv_accept;
    logic                         resv_reject;

    // A reservation on a busy register is only legal when that register is being
    // written in the same cycle (the load completes and a new one starts).
    assign wr_same     = LD_REG && (DR == RESV_DR);
    assign resv_accept = RESV && (!busy[RESV_DR] || wr_same);
    assign resv_reject = RESV && busy[RESV_DR] && !wr_same;

    // Next busy vector: a write clears its bit, an accepted reserve sets it and wins ties.
    always_comb begin
        busy_nxt = busy;
        if (LD_REG)
            busy_nxt[DR] = 1'b0;
        if (resv_accept)
            busy_nxt[RESV_DR] = 1'b1;
    end

    // Register storage update.
    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            regs <= '0;
        else if (LD_REG)
            regs[DR] <= BUS;
    end

    // Scoreboard, condition codes and reservation error pulse.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            busy       <= '0;
            nzp_q      <= NZP_RST;
            resv_err_q <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            resv_err_q <= resv_reject;
            if (LD_CC)
                nzp_q <= nzp_of(MAX_DATA_W'(BUS), DATA_W);
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_port1 (
        .regs     (regs),
        .busy     (busy),
        .sel      (SR1_SEL),
        .wr_data  (BUS),
        .wr_idx   (DR),
        .wr_en    (LD_REG),
        .resv_idx (RESV_DR),
        .resv_en  (RESV),
        .rd_data  (SR1_OUT),
        .rd_busy  (SR1_BUSY)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_port2 (
        .regs     (regs),
        .busy     (busy),
        .sel      (SR2_SEL),
        .wr_data  (BUS),
        .wr_idx   (DR),
        .wr_en    (LD_REG),
        .resv_idx (RESV_DR),
        .resv_en  (RESV),
        .rd_data  (SR2_OUT),
        .rd_busy  (SR2_BUSY)
    );

    assign STALL    = SR1_BUSY | SR2_BUSY;
    assign NZP      = nzp_q;
    assign RESV_ERR = resv_err_q;

endmodule

// File: tb/tb_regfile_cc_sb.sv
// Directed bench: default build, a no-forwarding build and a 32x16 build.
module tb_regfile_cc_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus;
    logic [2:0]  dr, resv_dr, s1, s2;
    logic        ld_reg, ld_cc, resv;

    logic [15:0] a_sr1, a_sr2, b_sr1, b_sr2;
    logic        a_b1, a_b2, a_stall, a_err, b_b1, b_b2, b_stall, b_err;
    logic [2:0]  a_nzp, b_nzp;

    logic [31:0] c_bus, c_sr1, c_sr2;
    logic [3:0]  c_dr, c_resv_dr, c_s1, c_s2;
    logic        c_ld_reg, c_ld_cc, c_resv, c_b1, c_b2, c_stall, c_err;
    logic [2:0]  c_nzp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_cc_sb #(.DATA_W(16), .NREGS(8), .BYPASS(1)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .BUS(bus), .DR(dr), .LD_REG(ld_reg), .LD_CC(ld_cc),
        .RESV(resv), .RESV_DR(resv_dr), .SR1_SEL(s1), .SR2_SEL(s2),
        .SR1_OUT(a_sr1), .SR2_OUT(a_sr2), .SR1_BUSY(a_b1), .SR2_BUSY(a_b2),
        .STALL(a_stall), .NZP(a_nzp), .RESV_ERR(a_err));

    regfile_cc_sb #(.DATA_W(16), .NREGS(8), .BYPASS(0)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .BUS(bus), .DR(dr), .LD_REG(ld_reg), .LD_CC(ld_cc),
        .RESV(resv), .RESV_DR(resv_dr), .SR1_SEL(s1), .SR2_SEL(s2),
        .SR1_OUT(b_sr1), .SR2_OUT(b_sr2), .SR1_BUSY(b_b1), .SR2_BUSY(b_b2),
        .STALL(b_stall), .NZP(b_nzp), .RESV_ERR(b_err));

    regfile_cc_sb #(.DATA_W(32), .NREGS(16), .BYPASS(1)) dut_c (
        .i_Clk(clk), .i_Rst(rst), .BUS(c_bus), .DR(c_dr), .LD_REG(c_ld_reg), .LD_CC(c_ld_cc),
        .RESV(c_resv), .RESV_DR(c_resv_dr), .SR1_SEL(c_s1), .SR2_SEL(c_s2),
        .SR1_OUT(c_sr1), .SR2_OUT(c_sr2), .SR1_BUSY(c_b1), .SR2_BUSY(c_b2),
        .STALL(c_stall), .NZP(c_nzp), .RESV_ERR(c_err));

    typedef struct {
        logic [15:0] bus;
        logic [2:0]  dr;
        logic [2:0]  ctl;     // {ld_reg, ld_cc, resv}
        logic [2:0]  rdr;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [15:0] e_sr1;
        logic [15:0] e_sr2;
        logic [3:0]  e_flg;   // {sr1_busy, sr2_busy, stall, resv_err}
        logic [2:0]  e_nzp;
        logic [15:0] n_sr1;   // no-forwarding build
        logic [15:0] n_sr2;
        logic        n_stall;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus = '0; dr = '0; ld_reg = 1'b0; ld_cc = 1'b0; resv = 1'b0; resv_dr = '0;
        s1 = '0; s2 = '0;
        c_bus = '0; c_dr = '0; c_ld_reg = 1'b0; c_ld_cc = 1'b0; c_resv = 1'b0;
        c_resv_dr = '0; c_s1 = '0; c_s2 = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'h0000, 3'd0, 3'b000, 3'd0, 3'd0, 3'd7, 16'h0000, 16'h0000, 4'b0000, 3'b010, 16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{16'h8001, 3'd3, 3'b110, 3'd0, 3'd3, 3'd0, 16'h8001, 16'h0000, 4'b0000, 3'b010, 16'h0000, 16'h0000, 1'b0};
        vecs[2]  = '{16'h0000, 3'd0, 3'b010, 3'd0, 3'd3, 3'd0, 16'h8001, 16'h0000, 4'b0000, 3'b100, 16'h8001, 16'h0000, 1'b0};
        vecs[3]  = '{16'h0005, 3'd0, 3'b010, 3'd0, 3'd3, 3'd0, 16'h8001, 16'h0000, 4'b0000, 3'b010, 16'h8001, 16'h0000, 1'b0};
        vecs[4]  = '{16'h0000, 3'd0, 3'b000, 3'd0, 3'd3, 3'd0, 16'h8001, 16'h0000, 4'b0000, 3'b001, 16'h8001, 16'h0000, 1'b0};
        vecs[5]  = '{16'h1234, 3'd5, 3'b100, 3'd0, 3'd3, 3'd5, 16'h8001, 16'h1234, 4'b0000, 3'b001, 16'h8001, 16'h0000, 1'b0};
        vecs[6]  = '{16'h0000, 3'd0, 3'b001, 3'd2, 3'd5, 3'd5, 16'h1234, 16'h1234, 4'b0000, 3'b001, 16'h1234, 16'h1234, 1'b0};
        vecs[7]  = '{16'h0000, 3'd0, 3'b000, 3'd0, 3'd2, 3'd0, 16'h0000, 16'h0000, 4'b1010, 3'b001, 16'h0000, 16'h0000, 1'b1};
        vecs[8]  = '{16'h00AA, 3'd2, 3'b100, 3'd0, 3'd2, 3'd0, 16'h00AA, 16'h0000, 4'b0000, 3'b001, 16'h0000, 16'h0000, 1'b1};
        vecs[9]  = '{16'h0000, 3'd0, 3'b000, 3'd0, 3'd2, 3'd0, 16'h00AA, 16'h0000, 4'b0000, 3'b001, 16'h00AA, 16'h0000, 1'b0};
        vecs[10] = '{16'h0000, 3'd0, 3'b001, 3'd2, 3'd2, 3'd0, 16'h00AA, 16'h0000, 4'b0000, 3'b001, 16'h00AA, 16'h0000, 1'b0};
        vecs[11] = '{16'h0000, 3'd0, 3'b001, 3'd2, 3'd2, 3'd0, 16'h00AA, 16'h0000, 4'b1010, 3'b001, 16'h00AA, 16'h0000, 1'b1};
        vecs[12] = '{16'h0000, 3'd0, 3'b000, 3'd0, 3'd2, 3'd0, 16'h00AA, 16'h0000, 4'b1011, 3'b001, 16'h00AA, 16'h0000, 1'b1};
        vecs[13] = '{16'h0000, 3'd0, 3'b000, 3'd0, 3'd2, 3'd0, 16'h00AA, 16'h0000, 4'b1010, 3'b001, 16'h00AA, 16'h0000, 1'b1};
        vecs[14] = '{16'h0055, 3'd2, 3'b101, 3'd2, 3'd2, 3'd0, 16'h0055, 16'h0000, 4'b1010, 3'b001, 16'h00AA, 16'h0000, 1'b1};
        vecs[15] = '{16'h0000, 3'd0, 3'b000, 3'd0, 3'd2, 3'd0, 16'h0055, 16'h0000, 4'b1010, 3'b001, 16'h0055, 16'h0000, 1'b1};
        vecs[16] = '{16'h0066, 3'd2, 3'b101, 3'd4, 3'd2, 3'd4, 16'h0066, 16'h0000, 4'b0000, 3'b001, 16'h0055, 16'h0000, 1'b1};
        vecs[17] = '{16'h0000, 3'd0, 3'b000, 3'd0, 3'd2, 3'd4, 16'h0066, 16'h0000, 4'b0110, 3'b001, 16'h0066, 16'h0000, 1'b1};
        vecs[18] = '{16'h0000, 3'd0, 3'b000, 3'd0, 3'd4, 3'd4, 16'h0000, 16'h0000, 4'b1110, 3'b001, 16'h0000, 16'h0000, 1'b1};

        // Reset, then sweep every register on both read ports.
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s1 = 3'(i);
            s2 = 3'(7 - i);
            #1;
            chk($sformatf("rst a_sr1 r%0d", i), 64'(a_sr1), 64'h0);
            chk($sformatf("rst a_sr2 r%0d", 7 - i), 64'(a_sr2), 64'h0);
        end
        for (int i = 0; i < 16; i++) begin
            c_s1 = 4'(i);
            #1;
            chk($sformatf("rst c_sr1 r%0d", i), 64'(c_sr1), 64'h0);
        end
        chk("rst a_nzp", 64'(a_nzp), 64'h2);
        chk("rst a_stall", 64'(a_stall), 64'h0);
        chk("rst a_err", 64'(a_err), 64'h0);
        chk("rst c_nzp", 64'(c_nzp), 64'h2);

        // Table of per-cycle vectors; expectations are the combinational view before the edge.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            bus = vecs[i].bus; dr = vecs[i].dr;
            {ld_reg, ld_cc, resv} = vecs[i].ctl;
            resv_dr = vecs[i].rdr; s1 = vecs[i].s1; s2 = vecs[i].s2;
            #1;
            chk($sformatf("v%0d a_sr1", i), 64'(a_sr1), 64'(vecs[i].e_sr1));
            chk($sformatf("v%0d a_sr2", i), 64'(a_sr2), 64'(vecs[i].e_sr2));
            chk($sformatf("v%0d a_flags", i), 64'({a_b1, a_b2, a_stall, a_err}), 64'(vecs[i].e_flg));
            chk($sformatf("v%0d a_nzp", i), 64'(a_nzp), 64'(vecs[i].e_nzp));
            chk($sformatf("v%0d b_sr1", i), 64'(b_sr1), 64'(vecs[i].n_sr1));
            chk($sformatf("v%0d b_sr2", i), 64'(b_sr2), 64'(vecs[i].n_sr2));
            chk($sformatf("v%0d b_stall", i), 64'(b_stall), 64'(vecs[i].n_stall));
        end

        // Wide build: write r15 with all ones and reserve r9 in the same cycle.
        @(negedge clk);
        idle_inputs();
        c_bus = 32'hFFFF_FFFF; c_dr = 4'd15; c_ld_reg = 1'b1; c_ld_cc = 1'b1;
        c_resv = 1'b1; c_resv_dr = 4'd9; c_s1 = 4'd15;
        #1;
        chk("c bypass sr1", 64'(c_sr1), 64'hFFFF_FFFF);
        @(negedge clk);
        c_ld_reg = 1'b0; c_ld_cc = 1'b0; c_resv = 1'b0; c_bus = '0;
        c_s1 = 4'd15; c_s2 = 4'd9;
        #1;
        chk("c r15", 64'(c_sr1), 64'hFFFF_FFFF);
        chk("c nzp", 64'(c_nzp), 64'h4);
        chk("c r9 busy", 64'(c_b2), 64'h1);
        chk("c stall", 64'(c_stall), 64'h1);

        // Rejected reserve of busy r4, then reset mid-reservation with competing inputs.
        @(negedge clk);
        resv = 1'b1; resv_dr = 3'd4;
        @(negedge clk);
        resv = 1'b0;
        #1;
        chk("pre-rst a_err", 64'(a_err), 64'h1);
        @(negedge clk);
        rst = 1'b1;
        bus = 16'h7777; dr = 3'd1; ld_reg = 1'b1; ld_cc = 1'b1; resv = 1'b1; resv_dr = 3'd6;
        c_bus = 32'h1; c_dr = 4'd3; c_ld_reg = 1'b1; c_resv = 1'b1; c_resv_dr = 4'd5;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        s1 = 3'd4; s2 = 3'd2;
        c_s1 = 4'd15; c_s2 = 4'd9;
        #1;
        chk("post-rst a r4 busy", 64'(a_b1), 64'h0);
        chk("post-rst a r2 busy", 64'(a_b2), 64'h0);
        chk("post-rst a r2 data", 64'(a_sr2), 64'h0);
        chk("post-rst a stall", 64'(a_stall), 64'h0);
        chk("post-rst a nzp", 64'(a_nzp), 64'h2);
        chk("post-rst a err", 64'(a_err), 64'h0);
        chk("post-rst c r15", 64'(c_sr1), 64'h0);
        chk("post-rst c r9 busy", 64'(c_b2), 64'h0);
        chk("post-rst c nzp", 64'(c_nzp), 64'h2);
        s1 = 3'd1; s2 = 3'd6; c_s1 = 4'd3; c_s2 = 4'd5;
        #1;
        chk("post-rst a r1 data", 64'(a_sr1), 64'h0);
        chk("post-rst a r6 busy", 64'(a_b2), 64'h0);
        chk("post-rst c r3 data", 64'(c_sr1), 64'h0);
        chk("post-rst c r5 busy", 64'(c_b2), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
